// File: rtl/systolic_array_load_sequencer_if.sv
// Row stream between the scratchpad read port, the load sequencer and the array control unit.
// master = sequencer side, slave = environment (memory stream + control unit).
interface systolic_array_load_sequencer_if #(
   parameter int unsigned array_dim = 4,
   parameter int unsigned data_w    = 16
);
   logic                          in_valid;
   logic                          in_ready;
   logic [array_dim*data_w-1:0]   in_data;
   logic                          fifo_has_space;
   logic                          weight_en;
   logic                          input_en;
   logic                          partial_en;
   logic [$clog2(array_dim)-1:0]  row_en;
   logic [array_dim*data_w-1:0]   out_data;

   modport master (
      input  in_valid, in_data, fifo_has_space,
      output in_ready, weight_en, input_en, partial_en, row_en, out_data
   );

   modport slave (
      output in_valid, in_data, fifo_has_space,
      input  in_ready, weight_en, input_en, partial_en, row_en, out_data
   );
endinterface

// File: rtl/systolic_array_load_sequencer.sv
// Streams one tile per job into the systolic array: weight rows, then input rows,
// each optionally followed by its partial-sum row. Output beats are registered (latency 1).
module systolic_array_load_sequencer #(
   parameter int unsigned array_dim = 4,
   parameter int unsigned data_w    = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   input  logic cfg_partials,
   input  logic cfg_reuse_weights,
   output logic busy,
   output logic done,
   systolic_array_load_sequencer_if.master bus
);
   localparam int unsigned row_w = $clog2(array_dim);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WEIGHT  = 3'd1;
   localparam logic [2:0] INPUT   = 3'd2;
   localparam logic [2:0] PARTIAL = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]       state;
   logic [row_w-1:0] row;
   logic             partials_q;
   logic             xfer;
   logic             last_row;

   // Weight rows go straight into the MACs, so only input/partial rows are throttled.
   always_comb begin
      bus.in_ready = 1'b0;
      case (state)
         WEIGHT:         bus.in_ready = 1'b1;
         INPUT, PARTIAL: bus.in_ready = bus.fifo_has_space;
         default:        bus.in_ready = 1'b0;
      endcase
   end

   assign xfer     = bus.in_valid && bus.in_ready;
   assign last_row = &row;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= IDLE;
         row            <= '0;
         partials_q     <= 1'b0;
         bus.weight_en  <= 1'b0;
         bus.input_en   <= 1'b0;
         bus.partial_en <= 1'b0;
         bus.row_en     <= '0;
         bus.out_data   <= '0;
      end else begin
         bus.weight_en  <= xfer && (state == WEIGHT);
         bus.input_en   <= xfer && (state == INPUT);
         bus.partial_en <= xfer && (state == PARTIAL);
         if (xfer) begin
            bus.out_data <= bus.in_data;
            bus.row_en   <= row;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  partials_q <= cfg_partials;
                  row        <= '0;
                  state      <= cfg_reuse_weights ? INPUT : WEIGHT;
               end
            end
            WEIGHT: begin
               if (xfer) begin
                  row <= row + 1'b1;
                  if (last_row) state <= INPUT;
               end
            end
            // With partials, the row index advances only after the partial row of the pair.
            INPUT: begin
               if (xfer) begin
                  if (partials_q) begin
                     state <= PARTIAL;
                  end else begin
                     row <= row + 1'b1;
                     if (last_row) state <= DONE;
                  end
               end
            end
            PARTIAL: begin
               if (xfer) begin
                  row   <= row + 1'b1;
                  state <= last_row ? DONE : INPUT;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/systolic_array_load_sequencer.md
Name: systolic_array_load_sequencer

Overview:
- Memory-side driver of the systolic array control unit's load inputs. Produces `weight_en`, `input_en`, `partial_en` and `row_en` together with the matching row data bus.
- For each job, it streams one tile: `array_dim` weight rows, then `array_dim` input rows, each input row optionally followed by its partial-sum row.
- Accepts rows from the scratchpad/memory read stream through a valid/ready handshake.
- Throttles input and partial rows on the control unit's `fifo_has_space`.

Parameters:
- `array_dim`, 4, systolic array dimension (rows per phase); power of two ≥ 2.
- `data_w`, 16, element width (FP16).

Ports:
- `CLK`  input  1  clock.
- `RST`  input  1  synchronous active-high reset.
- `start`  input  1  job start request; accepted only in IDLE.
- `cfg_partials`  input  1  sampled at accepted start; 1 = send a partial row after each input row.
- `cfg_reuse_weights`  input  1  sampled at accepted start; 1 = skip the weight phase.
- `busy`  output  1  job in progress (state ≠ IDLE).
- `done`  output  1  one-cycle pulse when the job's last row has been issued.
- `in_valid`  input  1  upstream row valid.
- `in_ready`  output  1  sequencer accepts a row this cycle.
- `in_data`  input  `array_dim*data_w`  upstream row; element 0 is in the LSBs.
- `fifo_has_space`  input  1  from the control unit; FIFOs can take input/partial rows.
- `weight_en`  output  1  `out_data` is a weight row.
- `input_en`  output  1  `out_data` is an input row.
- `partial_en`  output  1  `out_data` is a partial-sum row.
- `row_en`  output  `$clog2(array_dim)`  destination row index of the current beat.
- `out_data`  output  `array_dim*data_w`  row data to the array.

Behaviour:
- **Reset.** While `RST`=1 at a `CLK` edge:
  - state ← IDLE, row counter ← 0, config registers ← 0.
  - `busy`, `done`, `in_ready`, `weight_en`, `input_en`, `partial_en` = 0; `row_en` = 0; `out_data` = 0.
  - Reset mid-job discards the job. No further beats and no `done` are produced.
- **States.** IDLE, WEIGHT, INPUT, PARTIAL, DONE.
- **IDLE → job start.** `start`=1 latches `cfg_*`, clears the row counter and moves to:
  - WEIGHT, if `cfg_reuse_weights`=0;
  - INPUT, otherwise.
  - `start` in any other state is ignored.
- **Handshake.** A transfer occurs on a cycle where `in_valid`=1 and `in_ready`=1.
  - `in_ready` is combinational: 1 in WEIGHT; equal to `fifo_has_space` in INPUT or PARTIAL; 0 in IDLE and DONE.
  - Weight rows load directly into the MACs and are never throttled.
- **Output registering (latency 1).** On a transfer cycle, at the next edge:
  - `out_data` ← `in_data`;
  - `row_en` ← row counter;
  - exactly one of `weight_en` / `input_en` / `partial_en` ← 1, according to the current state.
  - On a cycle with no transfer, all three enables are 0 at the next edge. `out_data` and `row_en` hold their previous values.
- **Slack requirement.** `fifo_has_space` is sampled in the transfer cycle and the beat reaches the array one cycle later. The control unit deasserts `fifo_has_space` with at least one row of slack.
- **WEIGHT.** Each transfer increments the row counter. When the transfer occurs at row `array_dim-1`: counter wraps to 0 and state → INPUT.
- **INPUT.** On transfer:
  - if `cfg_partials`=1: state → PARTIAL; counter unchanged;
  - else: counter increments, or wraps to 0 and state → DONE if at row `array_dim-1`.
- **PARTIAL.** On transfer: counter increments, or wraps to 0 and state → DONE if at row `array_dim-1`; otherwise state → INPUT.
- **DONE.** `done`=1 for exactly this one cycle, then state → IDLE. `busy`=0 from that IDLE cycle onward.
  - The last beat's enable is visible in the same cycle as `done`.
  - `start` is accepted again on the first IDLE cycle (one dead cycle between jobs).
- **Beat counts per job.**
  - Weight rows: `array_dim`, or 0 with reuse.
  - Input rows: `array_dim`.
  - Partial rows: `array_dim` if `cfg_partials`=1, else 0.
  - Row order is ascending 0..`array_dim-1` in every phase.
- **Simultaneous events.** `RST` has priority over everything. `in_valid` with `in_ready`=0 stalls with no state change. Stalls may last indefinitely; there is no timeout.
- **Width rules.** The row counter is `$clog2(array_dim)` bits and wraps naturally at `array_dim-1`. `out_data` is an unmodified copy of `in_data`.

Test Plan:
- **Basic, no partials.** `array_dim`=4, `cfg_partials`=0, `cfg_reuse_weights`=0, `in_valid` held 1, `fifo_has_space`=1, rows = 0x0001..0x0008 replicated → 4 `weight_en` beats with `row_en` 0,1,2,3, then 4 `input_en` beats with `row_en` 0..3; data matches in order; `done` pulses once, 9 cycles after start.
- **Partials interleave.** `cfg_partials`=1 → beat sequence I0,P0,I1,P1,I2,P2,I3,P3 after W0..W3; each partial row carries the same `row_en` as its preceding input row; 12 beats total.
- **Weight reuse.** `cfg_reuse_weights`=1, `cfg_partials`=0 → no `weight_en` ever; first beat is `input_en` with `row_en`=0; `done` after 4 beats.
- **Backpressure.** During INPUT, drop `fifo_has_space` for 5 cycles at row 2 → `in_ready`=0, no enables, `row_en` holds; on release, I2 is issued with its data intact. The same drop during WEIGHT leaves weight beats unaffected.
- **Reset mid-job.** Assert `RST` after W2 → next cycle all outputs are 0 and `busy`=0; no `done` is produced. A new start then begins at W0.
- **Ignored start.** `start` pulsed while `busy`=1 → no change; job completes normally; `start` held through the DONE cycle launches the next job on the following IDLE cycle.
